// File: rtl/multi_channel_throttle_limiter_if.sv
// multi_channel_throttle_limiter_if: start/active/complete handshake plus packed channel value buses
interface multi_channel_throttle_limiter_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic                      start_signal;
    logic [CHANNELS*WIDTH-1:0] throttle_in;
    logic [CHANNELS*WIDTH-1:0] throttle_out;
    logic                      active_signal;
    logic                      complete_signal;

    modport master (
        output start_signal, throttle_in,
        input  throttle_out, active_signal, complete_signal
    );

    modport slave (
        input  start_signal, throttle_in,
        output throttle_out, active_signal, complete_signal
    );
endinterface

// File: rtl/multi_channel_throttle_limiter.sv
// multi_channel_throttle_limiter: per-channel running-sum moving average, one channel per clock; optional SLEW_LIMIT_EN output clamp
module multi_channel_throttle_limiter #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 8,
    parameter int DEPTH_LOG2     = 3,
    parameter int IDLE_THRESHOLD = 10,
    parameter int MAX_STEP       = 16
) (
    input logic us_clk,
    input logic resetn,
    multi_channel_throttle_limiter_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = WIDTH + DEPTH_LOG2;
    localparam int CW    = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {WAIT, LATCH, UPDATE, COMPLETE} state_t;

    if (MAX_STEP < 1) begin : g_bad_step
        $error("MAX_STEP must be positive");
    end

    state_t                    state;
    logic                      start_q;
    logic                      active_q;
    logic                      complete_q;
    logic [CHANNELS*WIDTH-1:0] out_q;
    logic [DEPTH_LOG2-1:0]     wr_ptr;
    logic [CW-1:0]             ch_idx;
    logic [WIDTH-1:0]          lat   [CHANNELS];
    logic [SW-1:0]             sum_q [CHANNELS];
    logic [WIDTH-1:0]          buf_q [CHANNELS][DEPTH];

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] old;
    logic [SW-1:0]    nsum;
    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] nout;

    // Incremental sum and floor average for the channel selected by ch_idx
    always_comb begin
        x    = lat[ch_idx];
        old  = buf_q[ch_idx][wr_ptr];
        nsum = sum_q[ch_idx] + SW'(x) - SW'(old);
        avg  = WIDTH'(nsum >> DEPTH_LOG2);
    end

`ifdef SLEW_LIMIT_EN
    logic [WIDTH-1:0] prev;
    int               avg_i;
    int               prev_i;

    // Clamp the new output to within MAX_STEP of the channel's previous output
    always_comb begin
        prev   = out_q[ch_idx*WIDTH +: WIDTH];
        avg_i  = int'(avg);
        prev_i = int'(prev);
        nout   = avg_i > prev_i + MAX_STEP ? WIDTH'(prev_i + MAX_STEP) :
                 avg_i < prev_i - MAX_STEP ? WIDTH'(prev_i - MAX_STEP) : avg;
    end
`else
    assign nout = avg;
`endif

    // Pass sequencer: latch inputs, update channels in turn, pulse complete, advance wr_ptr
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state      <= WAIT;
            start_q    <= 1'b0;
            active_q   <= 1'b0;
            complete_q <= 1'b0;
            out_q      <= '0;
            wr_ptr     <= '0;
            ch_idx     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                lat[c]   <= '0;
                sum_q[c] <= '0;
                for (int d = 0; d < DEPTH; d++) buf_q[c][d] <= '0;
            end
        end else begin
            start_q <= bus.start_signal;
            case (state)
                WAIT: begin
                    if (bus.start_signal && !start_q) begin
                        state    <= LATCH;
                        active_q <= 1'b1;
                    end
                end
                LATCH: begin
                    for (int c = 0; c < CHANNELS; c++) lat[c] <= bus.throttle_in[c*WIDTH +: WIDTH];
                    ch_idx <= '0;
                    state  <= UPDATE;
                end
                UPDATE: begin
                    if (x < IDLE_THRESHOLD) begin
                        for (int d = 0; d < DEPTH; d++) buf_q[ch_idx][d] <= '0;
                        sum_q[ch_idx]                 <= '0;
                        out_q[ch_idx*WIDTH +: WIDTH]  <= '0;
                    end else begin
                        buf_q[ch_idx][wr_ptr]         <= x;
                        sum_q[ch_idx]                 <= nsum;
                        out_q[ch_idx*WIDTH +: WIDTH]  <= nout;
                    end
                    if (ch_idx == CW'(CHANNELS - 1)) begin
                        state      <= COMPLETE;
                        active_q   <= 1'b0;
                        complete_q <= 1'b1;
                    end
                    ch_idx <= ch_idx + 1'b1;
                end
                COMPLETE: begin
                    complete_q <= 1'b0;
                    wr_ptr     <= wr_ptr + 1'b1;
                    state      <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

    assign bus.throttle_out    = out_q;
    assign bus.active_signal   = active_q;
    assign bus.complete_signal = complete_q;
endmodule

// File: tb/tb_multi_channel_throttle_limiter.sv
// tb_multi_channel_throttle_limiter: directed plus randomized passes checked against a queue-based moving-average model
module tb_multi_channel_throttle_limiter;
    localparam int CH       = 4;
    localparam int W        = 8;
    localparam int DL       = 3;
    localparam int DEPTH    = 1 << DL;
    localparam int IDLE     = 10;
    localparam int MAX_STEP = 16;

    logic us_clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   hist [CH][$];
    int   exp_out [CH];
    int   in_v [CH];

    multi_channel_throttle_limiter_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    multi_channel_throttle_limiter #(
        .CHANNELS(CH), .WIDTH(W), .DEPTH_LOG2(DL), .IDLE_THRESHOLD(IDLE), .MAX_STEP(MAX_STEP)
    ) dut (
        .us_clk(us_clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 us_clk = ~us_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_of(input int k);
        return int'(bus.throttle_out[k*W +: W]);
    endfunction

    task automatic set_in();
        for (int k = 0; k < CH; k++) bus.throttle_in[k*W +: W] = W'(in_v[k]);
    endtask

    // Average of the last DEPTH accepted samples since the last idle, empty slots count as zero
    function automatic void model_step();
        for (int k = 0; k < CH; k++) begin
            int s;
            int a;
            s = 0;
            if (in_v[k] < IDLE) begin
                hist[k].delete();
                exp_out[k] = 0;
            end else begin
                hist[k].push_back(in_v[k]);
                if (hist[k].size() > DEPTH) void'(hist[k].pop_front());
                for (int i = 0; i < hist[k].size(); i++) s += hist[k][i];
                a = s / DEPTH;
`ifdef SLEW_LIMIT_EN
                if (a > exp_out[k] + MAX_STEP) a = exp_out[k] + MAX_STEP;
                else if (a < exp_out[k] - MAX_STEP) a = exp_out[k] - MAX_STEP;
`endif
                exp_out[k] = a;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < CH; k++) begin
            hist[k].delete();
            exp_out[k] = 0;
        end
    endfunction

    task automatic run_pass(input int hold, input bit glitch);
        int old_out [CH];
        int pulses;
        int act;
        int last;
        pulses  = 0;
        old_out = exp_out;
        set_in();
        model_step();
        @(negedge us_clk);
        bus.start_signal = 1'b1;
        @(posedge us_clk);
        #1;
        chk("active_at_start", int'(bus.active_signal), 1);
        chk("complete_at_start", int'(bus.complete_signal), 0);
        act  = int'(bus.active_signal);
        last = (hold + 3 > CH + 5) ? hold + 3 : CH + 5;
        for (int e = 1; e <= last; e++) begin
            @(posedge us_clk);
            #1;
            act    += int'(bus.active_signal);
            pulses += int'(bus.complete_signal);
            if (e == CH + 1) chk("complete_pulse", int'(bus.complete_signal), 1);
            if (e == CH + 2) chk("complete_drop", int'(bus.complete_signal), 0);
            for (int k = 0; k < CH; k++) begin
                if (e == k + 1) chk($sformatf("ch%0d_before", k), out_of(k), old_out[k]);
                if (e == k + 2) chk($sformatf("ch%0d_after", k), out_of(k), exp_out[k]);
            end
            if (e == hold) bus.start_signal = 1'b0;
            if (glitch && e == 2) bus.start_signal = 1'b1;
            if (glitch && e == 3) bus.start_signal = 1'b0;
        end
        chk("complete_count", pulses, 1);
        chk("active_cycles", act, CH + 1);
    endtask

    initial begin
        int act;
        bus.start_signal = 1'b0;
        in_v = '{default: 0};
        set_in();
        model_reset();
        repeat (3) @(posedge us_clk);
        #1;
        chk("reset_out", int'(bus.throttle_out), 0);
        chk("reset_active", int'(bus.active_signal), 0);
        chk("reset_complete", int'(bus.complete_signal), 0);
        @(negedge us_clk);
        resetn = 1'b1;

        in_v = '{80, 0, 0, 0};
        repeat (9) run_pass(1, 0);
        chk("ramp_steady", out_of(0), 80);

        in_v[0] = 5;
        run_pass(1, 0);
        chk("idle_cut", out_of(0), 0);
        in_v[0] = 80;
        run_pass(1, 0);
        chk("restart_soft", out_of(0), 10);

        run_pass(20, 0);
        run_pass(1, 1);

        for (int p = 0; p < 8; p++) begin
            in_v[1] = 255;
            in_v[2] = (p % 2 == 0) ? 5 : 200;
            run_pass(1, 0);
        end
        chk("full_scale", out_of(1), 255);

        in_v = '{0, 0, 0, 0};
        run_pass(1, 0);
        in_v[0] = 200;
        repeat (13) run_pass(1, 0);
        chk("step_settled", out_of(0), 200);
        in_v[0] = 5;
        run_pass(1, 0);

        in_v = '{120, 90, 60, 30};
        run_pass(1, 0);
        set_in();
        @(negedge us_clk);
        bus.start_signal = 1'b1;
        repeat (4) @(posedge us_clk);
        #1;
        bus.start_signal = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midpass_rst_out", int'(bus.throttle_out), 0);
        chk("midpass_rst_active", int'(bus.active_signal), 0);
        chk("midpass_rst_complete", int'(bus.complete_signal), 0);
        @(negedge us_clk);
        resetn = 1'b1;
        model_reset();
        act = 0;
        repeat (10) begin
            @(posedge us_clk);
            #1;
            act += int'(bus.active_signal) + int'(bus.complete_signal);
        end
        chk("no_pass_after_reset", act, 0);

        repeat (40) begin
            int hold;
            for (int k = 0; k < CH; k++)
                in_v[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, IDLE - 1))
                                                       : int'($urandom_range(IDLE, (1 << W) - 1));
            hold = int'($urandom_range(1, 4));
            run_pass(hold, hold == 1 && $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
